// File: rtl/apcm_sbc4_pcm_serializer_if.sv
// Block-in / sample-out bus of the SBC4 PCM serializer.
// slave = serializer view, master = decoder + downstream sink view.
interface apcm_sbc4_pcm_serializer_if #(
    parameter int unsigned INPUT_WIDTH   = 16,
    parameter int unsigned CHANNEL_WIDTH = 2
);
    logic [INPUT_WIDTH-1:0]   s_tdata0;
    logic [INPUT_WIDTH-1:0]   s_tdata1;
    logic [INPUT_WIDTH-1:0]   s_tdata2;
    logic [INPUT_WIDTH-1:0]   s_tdata3;
    logic [CHANNEL_WIDTH-1:0] s_tid;
    logic                     s_tvalid;
    logic                     s_tready;

    logic [INPUT_WIDTH-1:0]   m_tdata;
    logic [CHANNEL_WIDTH-1:0] m_tid;
    logic                     m_tlast;
    logic                     m_tvalid;
    logic                     m_tready;

    modport slave (
        input  s_tdata0, s_tdata1, s_tdata2, s_tdata3, s_tid, s_tvalid,
        output s_tready,
        output m_tdata, m_tid, m_tlast, m_tvalid,
        input  m_tready
    );

    modport master (
        output s_tdata0, s_tdata1, s_tdata2, s_tdata3, s_tid, s_tvalid,
        input  s_tready,
        input  m_tdata, m_tid, m_tlast, m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/apcm_sbc4_pcm_serializer.sv
// Buffers 4-sample PCM blocks per channel and emits one TDM frame
// (channel 0 first) per fs_tick, inserting zeros on underrun.
module apcm_sbc4_pcm_serializer #(
    parameter int unsigned NR_CHANNELS   = 3,
    parameter int unsigned INPUT_WIDTH   = 16,
    parameter int unsigned DEPTH_BLOCKS  = 2,
    parameter int unsigned CHANNEL_WIDTH = $clog2(NR_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    apcm_sbc4_pcm_serializer_if.slave    io_pcm,
    input  logic                         i_fs_tick,
    input  logic                         i_clear_status,
    output logic [NR_CHANNELS-1:0]       o_underrun,
    output logic                         o_tick_lost
);
    localparam int unsigned SIZE    = 4 * DEPTH_BLOCKS;
    localparam int unsigned PTR_W   = $clog2(SIZE);
    localparam int unsigned CNT_W   = $clog2(SIZE + 1);
    localparam int unsigned LAST_CH = NR_CHANNELS - 1;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    state_t                   r_state;
    logic                     r_pending;
    logic [INPUT_WIDTH-1:0]   r_mem    [NR_CHANNELS][SIZE];
    logic [PTR_W-1:0]         r_wr_ptr [NR_CHANNELS];
    logic [PTR_W-1:0]         r_rd_ptr [NR_CHANNELS];
    logic [CNT_W-1:0]         r_count  [NR_CHANNELS];
    logic [INPUT_WIDTH-1:0]   r_m_tdata;
    logic [CHANNEL_WIDTH-1:0] r_m_tid;
    logic                     r_m_tlast;
    logic                     r_m_tvalid;
    logic [NR_CHANNELS-1:0]   r_underrun;
    logic                     r_tick_lost;

    logic                     w_tid_ok;
    logic [CHANNEL_WIDTH-1:0] w_tid_idx;
    logic                     w_wr;
    logic                     w_hs;
    logic                     w_load;
    logic [CHANNEL_WIDTH-1:0] w_load_ch;
    logic                     w_avail;
    logic [INPUT_WIDTH-1:0]   w_rd_data;
    logic [NR_CHANNELS-1:0]   w_wr_ch;
    logic [NR_CHANNELS-1:0]   w_ld_ch;
    logic [NR_CHANNELS-1:0]   w_rd_ch;
    logic [NR_CHANNELS-1:0]   w_underrun_set;
    logic                     w_tick_drop;

    // Circular pointer advance; explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned       k);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(SIZE)) begin
            sum = sum - (PTR_W+1)'(SIZE);
        end
        return sum[PTR_W-1:0];
    endfunction

    // Out-of-range channel ids are always accepted and dropped.
    assign w_tid_ok        = 32'(io_pcm.s_tid) < NR_CHANNELS;
    assign w_tid_idx       = w_tid_ok ? io_pcm.s_tid : CHANNEL_WIDTH'(0);
    assign io_pcm.s_tready = rst_n & (~w_tid_ok | (r_count[w_tid_idx] <= CNT_W'(SIZE - 4)));
    assign w_wr            = io_pcm.s_tvalid & io_pcm.s_tready & w_tid_ok;
    assign w_hs            = r_m_tvalid & io_pcm.m_tready;
    assign w_tick_drop     = i_fs_tick & r_pending;

    // Which channel (if any) is loaded into the output register this cycle.
    always_comb begin
        w_load    = 1'b0;
        w_load_ch = CHANNEL_WIDTH'(0);
        if (r_state == ST_IDLE) begin
            w_load = i_fs_tick | r_pending;
        end else if (w_hs && (r_m_tid != CHANNEL_WIDTH'(LAST_CH))) begin
            w_load    = 1'b1;
            w_load_ch = r_m_tid + CHANNEL_WIDTH'(1);
        end
    end

    assign w_avail   = r_count[w_load_ch] != CNT_W'(0);
    assign w_rd_data = w_avail ? r_mem[w_load_ch][r_rd_ptr[w_load_ch]] : INPUT_WIDTH'(0);

    always_comb begin
        w_wr_ch = '0;
        w_ld_ch = '0;
        w_rd_ch = '0;
        for (int c = 0; c < NR_CHANNELS; c++) begin
            w_wr_ch[c] = w_wr && (w_tid_idx == CHANNEL_WIDTH'(c));
            w_ld_ch[c] = w_load && (w_load_ch == CHANNEL_WIDTH'(c));
            w_rd_ch[c] = w_ld_ch[c] && (r_count[c] != CNT_W'(0));
        end
    end

    assign w_underrun_set = w_ld_ch & ~w_rd_ch;

    // Sample storage; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_tid_idx][ptr_add(r_wr_ptr[w_tid_idx], 0)] <= io_pcm.s_tdata0;
            r_mem[w_tid_idx][ptr_add(r_wr_ptr[w_tid_idx], 1)] <= io_pcm.s_tdata1;
            r_mem[w_tid_idx][ptr_add(r_wr_ptr[w_tid_idx], 2)] <= io_pcm.s_tdata2;
            r_mem[w_tid_idx][ptr_add(r_wr_ptr[w_tid_idx], 3)] <= io_pcm.s_tdata3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tid     <= '0;
            r_m_tlast   <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_underrun  <= '0;
            r_tick_lost <= 1'b0;
            for (int c = 0; c < NR_CHANNELS; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NR_CHANNELS; c++) begin
                if (w_wr_ch[c]) begin
                    r_wr_ptr[c] <= ptr_add(r_wr_ptr[c], 4);
                end
                if (w_rd_ch[c]) begin
                    r_rd_ptr[c] <= ptr_add(r_rd_ptr[c], 1);
                end
                r_count[c] <= r_count[c]
                            + (w_wr_ch[c] ? CNT_W'(4) : CNT_W'(0))
                            - (w_rd_ch[c] ? CNT_W'(1) : CNT_W'(0));
            end

            // Sticky flags: a new event beats a clear in the same cycle.
            r_underrun  <= (i_clear_status ? '0 : r_underrun) | w_underrun_set;
            r_tick_lost <= (i_clear_status ? 1'b0 : r_tick_lost) | w_tick_drop;

            case (r_state)
                ST_IDLE: begin
                    r_pending <= 1'b0;
                    if (w_load) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    r_pending <= r_pending | i_fs_tick;
                    if (w_hs && (r_m_tid == CHANNEL_WIDTH'(LAST_CH))) begin
                        r_state    <= ST_IDLE;
                        r_m_tvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_load) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_rd_data;
                r_m_tid    <= w_load_ch;
                r_m_tlast  <= (w_load_ch == CHANNEL_WIDTH'(LAST_CH));
            end
        end
    end

    assign io_pcm.m_tdata  = r_m_tdata;
    assign io_pcm.m_tid    = r_m_tid;
    assign io_pcm.m_tlast  = r_m_tlast;
    assign io_pcm.m_tvalid = r_m_tvalid;
    assign o_underrun      = r_underrun;
    assign o_tick_lost     = r_tick_lost;

endmodule
